// File: rtl/pri_enc_pkg.sv
// Shared helpers for the priority-encoder slice: index-width calculation and
// the multi-hit test used by the result register.
package pri_enc_pkg;

    // Widest request vector the multi-hit helper accepts.
    localparam int MAX_N = 256;

    // Number of bits needed to hold an index in [0, v-1].
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // True when two or more bits are set: clearing the lowest set bit
    // leaves something behind only if another bit was set.
    function automatic logic multi_hit(input logic [MAX_N-1:0] v);
        return |(v & (v - MAX_N'(1)));
    endfunction

endpackage

// File: rtl/pri_enc_find.sv
// Combinational rotate-search: finds the first set bit at or above `start`,
// wrapping from N-1 back to 0. Returns index 0 when no bit is set.
module pri_enc_find
    import pri_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         hit
);

    localparam logic [W:0] NW = (W+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;
    logic [W:0]     sum;

    // Rotate so `start` lands on bit 0, take the lowest set bit, then add the
    // start back modulo N (works for non-power-of-two N).
    always_comb begin
        dbl = {vec, vec};
        rot = dbl[{1'b0, start} +: N];
        off = '0;
        hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = W'(i);
                hit = 1'b1;
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= NW) begin
            sum = sum - NW;
        end
        idx = hit ? sum[W-1:0] : '0;
    end

endmodule

// File: rtl/pri_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides.
// Define PRI_ENC_RR_EN to compile in round-robin search (ptr register);
// otherwise the search always starts at bit 0 (lowest index wins).
module pri_encoder_rr
    import pri_enc_pkg::*;
#(
    parameter  int N = 8,          // 2 <= N <= MAX_N
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_req,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_any,
    output logic         out_multi,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] start_p0;
    logic [W-1:0] win_p0;
    logic         hit_p0;
    logic         multi_p0;
    logic         cap_p0;

    logic [W-1:0] idx_p1;
    logic         any_p1;
    logic         multi_p1;
    logic         vld_p1;

    // ---- stage p0: combinational search on the incoming vector ----
    // Ready while reset is held so upstream never sees a stall across reset.
    assign in_ready = !rst_n || !vld_p1 || out_ready;
    assign cap_p0   = rst_n && in_valid && in_ready;
    assign multi_p0 = multi_hit(MAX_N'(in_req));

    pri_enc_find #(.N(N)) u_find (
        .vec   (in_req),
        .start (start_p0),
        .idx   (win_p0),
        .hit   (hit_p0)
    );

`ifdef PRI_ENC_RR_EN
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] ptr;

    // Move the search start just past the last winner; empty captures and stalls keep it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (cap_p0 && hit_p0) begin
            ptr <= (win_p0 == LAST) ? '0 : win_p0 + 1'b1;
        end
    end

    assign start_p0 = ptr;
`else
    assign start_p0 = '0;
`endif

    // ---- stage p1: result register ----
    // Load on capture (also covers drain-and-refill); drop valid on a bare drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            idx_p1   <= '0;
            any_p1   <= 1'b0;
            multi_p1 <= 1'b0;
        end else if (cap_p0) begin
            vld_p1   <= 1'b1;
            idx_p1   <= win_p0;
            any_p1   <= hit_p0;
            multi_p1 <= multi_p0;
        end else if (out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_idx   = idx_p1;
    assign out_any   = any_p1;
    assign out_multi = multi_p1;

endmodule

// File: tb/tb_pri_encoder_rr.sv
// Self-checking bench for pri_encoder_rr (N=8 and N=5 instances) against a
// behavioural model of the search and handshake rules.
module tb_pri_encoder_rr;

`ifdef PRI_ENC_RR_EN
    localparam bit RR = 1'b1;
    int rot_exp[4] = '{0, 2, 7, 0};
    int w5_exp[3]  = '{0, 4, 0};
`else
    localparam bit RR = 1'b0;
    int rot_exp[4] = '{0, 0, 0, 0};
    int w5_exp[3]  = '{0, 0, 0};
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] in_req;
    logic       in_valid, in_ready, out_ready;
    logic [2:0] out_idx;
    logic       out_any, out_multi, out_valid;

    logic [4:0] req5;
    logic       v5, rdy5, ordy5;
    logic [2:0] idx5;
    logic       any5, multi5, ov5;

    int checks = 0;
    int errors = 0;

    // model state, [0] = N=8 instance, [1] = N=5 instance
    int mv[2], midx[2], many[2], mmul[2], mptr[2];
    int nn[2] = '{8, 5};

    pri_encoder_rr #(.N(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_valid(in_valid),
        .in_ready(in_ready), .out_idx(out_idx), .out_any(out_any),
        .out_multi(out_multi), .out_valid(out_valid), .out_ready(out_ready)
    );

    pri_encoder_rr #(.N(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_req(req5), .in_valid(v5),
        .in_ready(rdy5), .out_idx(idx5), .out_any(any5),
        .out_multi(multi5), .out_valid(ov5), .out_ready(ordy5)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // First set bit at or after `start`, searching upward with wrap-around.
    function automatic int ref_win(int n, logic [7:0] v, int start);
        for (int k = 0; k < n; k++) begin
            if (v[(start + k) % n]) return (start + k) % n;
        end
        return 0;
    endfunction

    task automatic model_edge(int d, logic [7:0] rq, logic iv, logic ordy, logic rn);
        int ones;
        if (!rn) begin
            mv[d] = 0; midx[d] = 0; many[d] = 0; mmul[d] = 0; mptr[d] = 0;
        end else if (iv && (mv[d] == 0 || ordy)) begin
            ones    = $countones(rq);
            mv[d]   = 1;
            many[d] = (ones > 0) ? 1 : 0;
            mmul[d] = (ones > 1) ? 1 : 0;
            midx[d] = (ones > 0) ? ref_win(nn[d], rq, RR ? mptr[d] : 0) : 0;
            if (RR && ones > 0) mptr[d] = (midx[d] + 1) % nn[d];
        end else if (mv[d] == 1 && ordy) begin
            mv[d] = 0;
        end
    endtask

    // One clock: check in_ready before the edge, advance model, check outputs after.
    task automatic cycle();
        logic [7:0] rq0, rq1;
        logic iv0, iv1, or0, or1, rn;
        #1;
        rq0 = in_req; rq1 = {3'b000, req5};
        iv0 = in_valid; iv1 = v5; or0 = out_ready; or1 = ordy5; rn = rst_n;
        chk("in_ready",  32'(in_ready), (!rn || mv[0] == 0 || or0) ? 1 : 0);
        chk("in_ready5", 32'(rdy5),     (!rn || mv[1] == 0 || or1) ? 1 : 0);
        @(posedge clk);
        model_edge(0, rq0, iv0, or0, rn);
        model_edge(1, rq1, iv1, or1, rn);
        #1;
        chk("out_valid", 32'(out_valid), mv[0]);
        chk("out_idx",   32'(out_idx),   midx[0]);
        chk("out_any",   32'(out_any),   many[0]);
        chk("out_multi", 32'(out_multi), mmul[0]);
        chk("out_valid5", 32'(ov5),    mv[1]);
        chk("out_idx5",   32'(idx5),   midx[1]);
        chk("out_any5",   32'(any5),   many[1]);
        chk("out_multi5", 32'(multi5), mmul[1]);
    endtask

    initial begin
        rst_n = 1'b0; in_req = '0; in_valid = 1'b0; out_ready = 1'b0;
        req5 = '0; v5 = 1'b0; ordy5 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; midx[i] = 0; many[i] = 0; mmul[i] = 0; mptr[i] = 0;
        end

        // reset state
        cycle(); cycle();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_idx",   32'(out_idx),   0);
        rst_n = 1'b1;

        // multi-hit vector
        in_req = 8'b0110_1000; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        chk("mh_idx",   32'(out_idx),   3);
        chk("mh_multi", 32'(out_multi), 1);
        chk("mh_valid", 32'(out_valid), 1);

        // zero vector is still a transfer
        in_req = 8'h00;
        cycle();
        chk("zero_any",   32'(out_any),   0);
        chk("zero_idx",   32'(out_idx),   0);
        chk("zero_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        cycle();
        chk("drain_valid", 32'(out_valid), 0);

        // rotation from a freshly reset pointer
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        in_req = 8'b1000_0101; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rot_idx", 32'(out_idx), rot_exp[k]);
        end

        // backpressure: capture idx 4, then stall three cycles
        in_req = 8'b0001_0000;
        cycle();
        chk("bp_cap", 32'(out_idx), 4);
        in_req = 8'b0000_0001; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 32'(in_ready), 0);
            cycle();
            chk("bp_hold", 32'(out_idx), 4);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", 32'(in_ready), 1);
        cycle();
        chk("bp_next", 32'(out_idx), 0);

        // reset mid-operation, input presented during reset is ignored
        out_ready = 1'b0; in_req = 8'hFF;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(in_ready), 1);
        cycle();
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_idx",   32'(out_idx),   0);
        rst_n = 1'b1; out_ready = 1'b1;
        cycle();
        chk("post_rst_idx", 32'(out_idx), 0);

        // non-power-of-two width
        in_valid = 1'b0;
        req5 = 5'b10001; v5 = 1'b1; ordy5 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("n5_idx", 32'(idx5), w5_exp[k]);
        end

        // randomized traffic on both instances
        for (int k = 0; k < 400; k++) begin
            in_req    = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
            req5      = ($urandom_range(7) == 0) ? 5'h00 : 5'($urandom);
            in_valid  = ($urandom_range(3) != 0);
            v5        = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            ordy5     = ($urandom_range(2) != 0);
            rst_n     = ($urandom_range(63) != 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
